cpu_prefetch_buffer: RTL and testbench
======================================

Name: cpu_prefetch_buffer

Overview:
- Parametrised instruction prefetch queue between the CPU fetch stage and the system memory port.
- Replaces the single blocking fetch per instruction with a DEPTH-entry FIFO of sequential opcodes.
- Handles both ARM (word, step 4) and Thumb (halfword, step 2) streams.
- Flushes on any non-sequential fetch (branch or mode change) and yields the memory port to data accesses via `hold`.

Parameters:
- DEPTH, 4: buffer entries; power of two, 2..16.
- CNT_W, 16: width of the statistics counters (used only with the optional feature).

Ports:
- clk, input, 1: clock.
- rstn, input, 1: reset. Synchronous, active-low.
- cpu_req, input, 1: fetch request; held high until cpu_ok.
- cpu_addr, input, 32: fetch address. Bits [1:0] are ignored in ARM mode, bit [0] in Thumb mode.
- cpu_thumb, input, 1: fetch width select; 1 = halfword, 0 = word.
- cpu_ok, output, 1: fetch complete this cycle.
- cpu_instr, output, 32: opcode, zero-extended in Thumb mode.
- hold, input, 1: data access pending; no new memory read may be issued.
- mem_addr, output, 32: memory read address.
- mem_width, output, 2: 1 = halfword, 2 = word.
- mem_read, output, 1: read request level.
- mem_rdata, input, 32: read data.
- mem_ok, input, 1: read complete; one-cycle pulse.
- hit_cnt, output, CNT_W: hit count (optional feature only).
- miss_cnt, output, CNT_W: miss count (optional feature only).

Behaviour:
- Reset values: cpu_ok=0, cpu_instr=0, mem_read=0, mem_addr=0, mem_width=2. Buffer empty, state IDLE, counters 0.
- Internal state:
  - head_addr: address of entry 0.
  - fill_addr: next address to request.
  - count: 0..DEPTH.
  - buf_thumb: mode of the buffered stream.
  - inflight flag.
  - stale flag.
- Step is 2 if buf_thumb, else 4. All address arithmetic is modulo 2^32 (0xFFFFFFFE+2 = 0).
- Hit: cpu_req && count>0 && aligned cpu_addr==head_addr && cpu_thumb==buf_thumb.
  - cpu_ok=1 in the same cycle, combinational from registered entry 0.
  - Pop entry 0; head_addr += step.
- Miss, otherwise with cpu_req and no hit, including a mode mismatch:
  - Flush: count=0; head_addr=fill_addr=aligned cpu_addr; buf_thumb=cpu_thumb.
  - If a read is in flight, set stale.
- Forwarding: while count==0, a non-stale in-flight read for head_addr that completes (mem_ok) with cpu_req high and matching gives cpu_ok=1 that cycle. cpu_instr=mem_rdata (Thumb: {16'h0, rdata[15:0]}). The data is not written to the buffer.
- Memory handshake:
  - mem_addr and mem_width stay stable and mem_read stays high from issue until mem_ok.
  - A request is never withdrawn, except by reset.
  - Stale completions are discarded and clear stale.
- Issue rule: a new read starts when all of the following hold: state FETCH, !inflight, !hold, and count + forwarded-pending < DEPTH. It uses fill_addr, and then fill_addr += step.
  - hold sampled high blocks only new issues; an in-flight read completes normally.
- FSM states:
  - IDLE: no stream.
  - FETCH: filling.
  - DRAIN: waiting out a stale read before the redirected stream starts.
- FSM transitions:
  - IDLE→FETCH on first cpu_req.
  - FETCH→DRAIN on a miss with inflight.
  - DRAIN→FETCH on mem_ok.
  - A miss without inflight stays in FETCH.
- Simultaneous cases:
  - Pop and fill in the same cycle: count unchanged; the write goes to the tail after the shift.
  - Full (count==DEPTH): no issue; mem_read stays low.
  - A miss in the same cycle as a non-stale mem_ok: the data is discarded.
- Reset mid-operation: the next cycle has mem_read=0 and the buffer is empty. The memory slave must accept abandonment on reset.

Optional Feature:
- Macro PREFETCH_STATS_EN.
- When defined:
  - hit_cnt increments on each hit cycle (cpu_ok from the buffer).
  - miss_cnt increments on each flush.
  - Both saturate at all-ones and are cleared by reset.
- When undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package cpu_pkg holds:
  - the state encodings PF_IDLE, PF_FETCH, PF_DRAIN;
  - the width codes W_BYTE=0, W_HALF=1, W_WORD=2, also used by the CPU load/store path.
- One sub-module, pf_fifo: DEPTH×32 shift FIFO with push, pop, flush and a count output.
- The FSM and address logic stay in the top module.

Test Plan:
- ARM sequential, 1-cycle memory:
  - cpu_req at 0x08000000, cpu_thumb=0.
  - First cpu_ok comes forwarded when mem_ok; mem_addr then steps 0x08000004, 0x08000008, …
  - Requests for 0x08000004 and 0x08000008 hit with cpu_ok in the same cycle.
- Full buffer:
  - DEPTH=4, CPU stalls.
  - After 4 fills mem_read stays 0. One pop lets the next issue at head+16 follow.
- Branch with read in flight (memory 3-cycle wait):
  - A request to 0x08000100 arrives while 0x08000010 is outstanding.
  - mem_read stays high on 0x08000010 until mem_ok, and that data is not delivered.
  - The next mem_addr is 0x08000100.
- Thumb switch:
  - A cpu_thumb=1 request at 0x08000201 flushes the buffer.
  - mem_width=1, fetches run 0x08000200, 0x08000202, …, cpu_instr[31:16]=0.
- hold:
  - hold=1 for 5 cycles blocks issue while the buffer still serves hits.
  - Issue resumes one cycle after hold falls.
  - Wrap check: head 0xFFFFFFFC in ARM mode, next fetch address is 0x00000000.
- PREFETCH_STATS_EN with CNT_W=4:
  - 20 hits give hit_cnt=15 (saturated).
  - 2 branches give miss_cnt=3, counting the initial miss.
  - Reset clears both counters.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared prefetch FSM states, memory width codes and fetch address alignment
package cpu_pkg;
  typedef enum logic [1:0] {PF_IDLE, PF_FETCH, PF_DRAIN} pf_state_t;
  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;
  function automatic logic [31:0] pf_align(input logic [31:0] a, input logic thumb);
    return thumb ? {a[31:1], 1'b0} : {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/pf_fifo.sv
// pf_fifo: DEPTH x 32 shift FIFO, entry 0 is the oldest; a push during a pop lands after the shift
module pf_fifo #(
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [31:0]   din,
  output logic [31:0]   dout,
  output logic [CW-1:0] count
);
  logic [31:0] mem [DEPTH];
  logic [CW-1:0] wi;
  assign wi = count - CW'(pop);
  assign dout = mem[0];
  always_ff @(posedge clk)
    if (!rstn || flush) count <= '0;
    else count <= count + CW'(push) - CW'(pop);
  always_ff @(posedge clk)
    for (int i = 0; i < DEPTH; i++)
      if (push && CW'(i) == wi) mem[i] <= din;
      else if (pop && i < DEPTH - 1) mem[i] <= mem[i + 1];
endmodule

// File: rtl/cpu_prefetch_buffer.sv
// cpu_prefetch_buffer: DEPTH-entry sequential opcode prefetch queue; PREFETCH_STATS_EN enables hit/miss counters
module cpu_prefetch_buffer import cpu_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cpu_req,
  input  logic [31:0]      cpu_addr,
  input  logic             cpu_thumb,
  output logic             cpu_ok,
  output logic [31:0]      cpu_instr,
  input  logic             hold,
  output logic [31:0]      mem_addr,
  output logic [1:0]       mem_width,
  output logic             mem_read,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ok,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam int CW = $clog2(DEPTH + 1);
  pf_state_t state, state_nx;
  logic [31:0] head_addr, fill_addr, addr_a, step, fifo_q, data;
  logic [CW-1:0] count;
  logic buf_thumb, inflight, stale, match, hit, fwd, miss, push, issue;
  assign inflight = mem_read;
  assign stale = state == PF_DRAIN;
  assign step = buf_thumb ? 32'd2 : 32'd4;
  assign addr_a = pf_align(cpu_addr, cpu_thumb);
  pf_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk(clk), .rstn(rstn), .push(push), .pop(hit), .flush(miss),
    .din(mem_rdata), .dout(fifo_q), .count(count)
  );
  always_ff @(posedge clk)
    if (!rstn) state <= PF_IDLE;
    else state <= state_nx;
  // a request matching the head of a live stream only ever waits, it never redirects
  always_comb begin
    state_nx = state;
    if (state == PF_IDLE && miss) state_nx = PF_FETCH;
    else if (state == PF_FETCH && miss && inflight && !mem_ok) state_nx = PF_DRAIN;
    else if (state == PF_DRAIN && mem_ok) state_nx = PF_FETCH;
  end
  always_comb begin
    match = state != PF_IDLE && addr_a == head_addr && cpu_thumb == buf_thumb;
    hit = cpu_req && match && count != '0;
    fwd = cpu_req && match && count == '0 && inflight && !stale && mem_ok;
    miss = cpu_req && !match;
    push = mem_ok && inflight && !stale && !miss && !fwd;
    issue = state == PF_FETCH && !inflight && !hold && !miss && count < CW'(DEPTH);
    data = fwd ? mem_rdata : fifo_q;
    cpu_ok = hit || fwd;
    cpu_instr = !cpu_ok ? 32'd0 : buf_thumb ? {16'd0, data[15:0]} : data;
  end
  always_ff @(posedge clk)
    if (!rstn) begin
      head_addr <= '0;
      fill_addr <= '0;
      buf_thumb <= 1'b0;
      mem_read <= 1'b0;
      mem_addr <= '0;
      mem_width <= W_WORD;
    end else begin
      if (miss) begin
        head_addr <= addr_a;
        fill_addr <= addr_a;
        buf_thumb <= cpu_thumb;
      end else begin
        if (cpu_ok) head_addr <= head_addr + step;
        if (issue) fill_addr <= fill_addr + step;
      end
      if (issue) begin
        mem_read <= 1'b1;
        mem_addr <= fill_addr;
        mem_width <= buf_thumb ? W_HALF : W_WORD;
      end else if (mem_ok) mem_read <= 1'b0;
    end
`ifdef PREFETCH_STATS_EN
  always_ff @(posedge clk)
    if (!rstn) begin
      hit_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit && !(&hit_cnt)) hit_cnt <= hit_cnt + CNT_W'(1);
      if (miss && !(&miss_cnt)) miss_cnt <= miss_cnt + CNT_W'(1);
    end
`else
  assign hit_cnt = '0;
  assign miss_cnt = '0;
`endif
endmodule

// File: tb/tb_cpu_prefetch_buffer.sv
// tb_cpu_prefetch_buffer: directed and random fetch traffic against a queue-level reference model
module tb_cpu_prefetch_buffer;
  import cpu_pkg::*;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;
  logic clk = 0, rstn = 0, cpu_req = 0, cpu_thumb = 0, hold = 0, mem_ok = 0;
  logic [31:0] cpu_addr = 0, mem_rdata = 0;
  logic cpu_ok, mem_read;
  logic [31:0] cpu_instr, mem_addr;
  logic [1:0] mem_width;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;
  int vectors = 0, errors = 0;
  logic [31:0] q[$];
  bit started, mthumb, out_valid, out_stale, prev_hold, last_ok, busy, rnd;
  logic [31:0] mhead, mfill, out_addr, last_issue, last_instr;
  int issues = 0, m_hits = 0, m_miss = 0, wt = 0, wmin = 0, wmax = 0, wait_cyc = 0, n = 0;
  always #5 clk = ~clk;
  cpu_prefetch_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_thumb(cpu_thumb),
    .cpu_ok(cpu_ok), .cpu_instr(cpu_instr), .hold(hold), .mem_addr(mem_addr),
    .mem_width(mem_width), .mem_read(mem_read), .mem_rdata(mem_rdata), .mem_ok(mem_ok),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction
  function automatic logic [31:0] algn(input logic [31:0] a, input bit t);
    return a & (t ? ~32'd1 : ~32'd3);
  endfunction
  function automatic logic [31:0] stp(input bit t);
    return t ? 32'd2 : 32'd4;
  endfunction
  task automatic slave();
    mem_ok = 0;
    mem_rdata = $urandom;
    if (!rstn) busy = 0;
    else if (mem_read) begin
      if (!busy) begin
        busy = 1;
        wt = $urandom_range(wmax, wmin);
      end
      if (wt == 0) begin
        mem_ok = 1;
        mem_rdata = mem_fn(mem_addr);
        busy = 0;
      end else wt--;
    end
  endtask
  task automatic model();
    logic [31:0] a, d;
    bit t, match, hit, fwd, miss;
    if (!rstn) begin
      q.delete();
      started = 0; mthumb = 0; out_valid = 0; out_stale = 0; prev_hold = 0; last_ok = 0;
      mhead = 0; mfill = 0; m_hits = 0; m_miss = 0;
      return;
    end
    if (mem_read && !out_valid) begin
      check("issue_addr", mem_addr, mfill);
      check("issue_width", mem_width, mthumb ? W_HALF : W_WORD);
      check("issue_room", q.size() < DEPTH, 1);
      check("issue_hold", prev_hold, 0);
      out_valid = 1; out_stale = 0; out_addr = mfill; last_issue = mem_addr;
      mfill += stp(mthumb);
      issues++;
    end else if (out_valid) begin
      check("read_held", mem_read, 1);
      check("addr_held", mem_addr, out_addr);
    end
    t = cpu_thumb;
    a = algn(cpu_addr, t);
    match = started && a == mhead && t == mthumb;
    hit = cpu_req && match && q.size() > 0;
    fwd = cpu_req && match && q.size() == 0 && out_valid && !out_stale && mem_ok;
    miss = cpu_req && !match;
    check("cpu_ok", cpu_ok, hit || fwd);
    if (cpu_ok && (hit || fwd)) begin
      d = mem_fn(a);
      check("cpu_instr", cpu_instr, t ? {16'h0, d[15:0]} : d);
      last_instr = cpu_instr;
    end
    if (mem_ok && out_valid) begin
      if (!out_stale && !miss && !fwd) q.push_back(out_addr);
      out_valid = 0; out_stale = 0;
    end
    if (hit) begin
      void'(q.pop_front());
      if (m_hits < CMAX) m_hits++;
    end
    if (hit || fwd) mhead += stp(mthumb);
    if (miss) begin
      q.delete();
      mhead = a; mfill = a; mthumb = t; started = 1;
      if (m_miss < CMAX) m_miss++;
      if (out_valid) out_stale = 1;
    end
    prev_hold = hold;
    last_ok = cpu_ok;
  endtask
  task automatic pick();
    int r;
    hold = ($urandom_range(3) == 0);
    if (cpu_req && !last_ok && wait_cyc < 100) begin
      wait_cyc++;
      return;
    end
    if (cpu_req && !last_ok) check("req_timeout", last_ok, 1);
    wait_cyc = 0;
    r = $urandom_range(99);
    if (r < 15) cpu_req = 0;
    else begin
      cpu_req = 1;
      if (r < 80) cpu_addr = algn(cpu_addr, cpu_thumb) + stp(cpu_thumb);
      else begin
        if (r >= 92) cpu_thumb = ~cpu_thumb;
        cpu_addr = ($urandom_range(7) == 0 ? 32'hFFFFFFF0 : 32'h08000000) + 32'($urandom_range(31)) * 2;
      end
      cpu_addr = cpu_addr | 32'($urandom_range(cpu_thumb ? 1 : 3));
    end
  endtask
  task automatic cycle();
    if (rnd) pick();
    slave();
    #1 model();
    @(negedge clk);
  endtask
  task automatic idle(input int k);
    repeat (k) cycle();
  endtask
  task automatic fetch(input logic [31:0] a, input bit t, output int cyc);
    cyc = 0;
    cpu_req = 1; cpu_addr = a; cpu_thumb = t;
    do begin
      cycle();
      cyc++;
    end while (!last_ok && cyc < 50);
    check("fetch_done", last_ok, 1);
    cpu_req = 0;
  endtask
  task automatic do_reset();
    rstn = 0; cpu_req = 0; hold = 0;
    idle(2);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_width", mem_width, W_WORD);
    check("rst_cpu_ok", cpu_ok, 0);
    check("rst_cpu_instr", cpu_instr, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    rstn = 1;
  endtask
  initial begin
    @(negedge clk);
    do_reset();
    fetch(32'h08000000, 0, n);
    check("first_fwd_cycles", n, 3);
    idle(10);
    check("full_issues", issues, 1 + DEPTH);
    check("full_no_read", mem_read, 0);
    fetch(32'h08000004, 0, n);
    check("hit_same_cycle", n, 1);
    idle(3);
    check("refill_addr", last_issue, 32'h08000014);
    fetch(32'h08000008, 0, n);
    check("hit2_same_cycle", n, 1);
    idle(3);
    hold = 1;
    fetch(32'h0800000C, 0, n);
    check("hold_hit", n, 1);
    fetch(32'h08000010, 0, n);
    idle(3);
    check("hold_issues", issues, 7);
    check("hold_no_read", mem_read, 0);
    hold = 0;
    cycle();
    check("hold_resume", mem_read, 1);
    check("hold_resume_addr", mem_addr, 32'h0800001C);
    do_reset();
    wmin = 2; wmax = 2;
    cpu_req = 1; cpu_addr = 32'h08000010; cpu_thumb = 0;
    idle(3);
    check("branch_pending", mem_addr, 32'h08000010);
    fetch(32'h08000100, 0, n);
    check("branch_target", last_issue, 32'h08000100);
    wmin = 0; wmax = 0;
    fetch(32'h08000201, 1, n);
    check("thumb_upper_fwd", last_instr >> 16, 0);
    idle(8);
    fetch(32'h08000203, 1, n);
    check("thumb_hit", n, 1);
    check("thumb_upper_hit", last_instr >> 16, 0);
    check("thumb_width", mem_width, W_HALF);
    fetch(32'hFFFFFFFC, 0, n);
    idle(2);
    check("wrap_issue", last_issue, 32'h00000000);
    fetch(32'h00000000, 0, n);
    check("wrap_hit", n, 1);
    do_reset();
    fetch(32'h08000000, 0, n);
    idle(2);
    for (int i = 0; i < 20; i++) begin
      fetch(32'h08000004 + 32'(i) * 4, 0, n);
      idle(2);
    end
    fetch(32'h08000400, 0, n);
    fetch(32'h08000800, 0, n);
    idle(2);
`ifdef PREFETCH_STATS_EN
    check("hit_cnt_sat", hit_cnt, CMAX);
    check("miss_cnt_3", miss_cnt, 3);
`else
    check("hit_cnt_off", hit_cnt, 0);
    check("miss_cnt_off", miss_cnt, 0);
`endif
    do_reset();
    wmin = 0; wmax = 3;
    rnd = 1;
    idle(1500);
    rnd = 0;
    do_reset();
    rnd = 1;
    idle(1500);
    rnd = 0; cpu_req = 0; hold = 0;
    idle(10);
`ifdef PREFETCH_STATS_EN
    check("rand_hit_cnt", hit_cnt, m_hits);
    check("rand_miss_cnt", miss_cnt, m_miss);
`else
    check("rand_hit_cnt_off", hit_cnt, 0);
    check("rand_miss_cnt_off", miss_cnt, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
